// File: rtl/grant_uart_tx_pkg.sv
// Shared definitions for the granted UART transmitter: FSM state
// encodings, frame data width and the default bit period.
package grant_uart_tx_pkg;

  localparam int DATA_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

endpackage

// File: rtl/grant_uart_tx_baud_counter.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1, wraps, and flags the
// terminal count. Held at zero while clear is high so every bit period
// that follows a state change starts from a fresh count.
module baud_counter
  import grant_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Free-running period count, zeroed by reset/clear and on wrap.
  always_ff @(posedge clock) begin
    if (reset || clear)  cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

// File: rtl/grant_uart_tx.sv
// UART transmitter fed by a two-requester arbiter. A grant seen in IDLE
// latches that source's byte and sends an 8N1 frame; a one-cycle done
// pulse names the source once the stop bit ends. Source 0 wins when
// both grants are high. All outputs come straight from flops.
module grant_uart_tx
  import grant_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 gnt_0,
  input  logic                 gnt_1,
  input  logic [DATA_BITS-1:0] data_0,
  input  logic [DATA_BITS-1:0] data_1,
  output logic                 txd,
  output logic                 busy,
  output logic                 done_0,
  output logic                 done_1
);

  state_t               state;
  logic [DATA_BITS-1:0] byte_q;
  logic [2:0]           bit_idx;
  logic                 src;
  logic                 tick;
  logic                 clear;

  // Counter idles at zero in IDLE; every other transition lands on a
  // tick, where the counter wraps to zero by itself.
  assign clear = (state == IDLE);

  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clock (clock),
    .reset (reset),
    .clear (clear),
    .tick  (tick)
  );

  // Frame sequencer with registered line, busy and done outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      txd     <= 1'b1;
      busy    <= 1'b0;
      done_0  <= 1'b0;
      done_1  <= 1'b0;
      byte_q  <= '0;
      bit_idx <= '0;
      src     <= 1'b0;
    end else begin
      done_0 <= 1'b0;
      done_1 <= 1'b0;
      case (state)
        IDLE: begin
          // The done cycle blocks acceptance so a held grant is not
          // taken twice for the same request.
          if (!done_0 && !done_1) begin
            if (gnt_0) begin
              byte_q  <= data_0;
              src     <= 1'b0;
              state   <= START;
              txd     <= 1'b0;
              busy    <= 1'b1;
              bit_idx <= '0;
            end else if (gnt_1) begin
              byte_q  <= data_1;
              src     <= 1'b1;
              state   <= START;
              txd     <= 1'b0;
              busy    <= 1'b1;
              bit_idx <= '0;
            end
          end
        end
        START: begin
          if (tick) begin
            state <= DATA;
            txd   <= byte_q[0];
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= byte_q[bit_idx + 3'd1];
            end
          end
        end
        STOP: begin
          if (tick) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done_0 <= !src;
            done_1 <= src;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_grant_uart_tx.sv
// Bench for grant_uart_tx at 4 clocks per bit. A frame-level reference
// model (cycles since acceptance -> expected line level) is advanced on
// every edge and compared against txd, busy, done_0 and done_1.
module tb_grant_uart_tx;

  localparam int N     = 4;
  localparam int FRAME = 10 * N;

  logic       clock = 1'b0;
  logic       reset;
  logic       gnt_0, gnt_1;
  logic [7:0] data_0, data_1;
  logic       txd, busy, done_0, done_1;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  // reference model state
  bit       m_act   = 1'b0;
  int       m_t     = 0;
  bit [7:0] m_byte  = '0;
  bit       m_src   = 1'b0;
  bit       m_pulse = 1'b0;
  bit       m_psrc  = 1'b0;

  grant_uart_tx #(.CLKS_PER_BIT(N)) dut (
    .clock  (clock),
    .reset  (reset),
    .gnt_0  (gnt_0),
    .gnt_1  (gnt_1),
    .data_0 (data_0),
    .data_1 (data_1),
    .txd    (txd),
    .busy   (busy),
    .done_0 (done_0),
    .done_1 (done_1)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
  endtask

  // Line level t cycles after acceptance: start bit, 8 data bits LSB
  // first, stop bit -- each N cycles long.
  function automatic bit frame_level(input int t, input bit [7:0] b);
    if (t < N)       return 1'b0;
    if (t < 9 * N)   return b[(t - N) / N];
    return 1'b1;
  endfunction

  task automatic model_edge(input bit r, input bit g0, input bit g1,
                            input bit [7:0] d0, input bit [7:0] d1);
    if (r) begin
      m_act   = 1'b0;
      m_pulse = 1'b0;
    end else if (m_act) begin
      if (m_t == FRAME - 1) begin
        m_act   = 1'b0;
        m_pulse = 1'b1;
        m_psrc  = m_src;
      end else begin
        m_t++;
      end
    end else if (m_pulse) begin
      m_pulse = 1'b0;
    end else if (g0) begin
      m_act = 1'b1; m_t = 0; m_byte = d0; m_src = 1'b0;
    end else if (g1) begin
      m_act = 1'b1; m_t = 0; m_byte = d1; m_src = 1'b1;
    end
  endtask

  // Drive one cycle of inputs, clock it, advance the model, compare.
  task automatic step(input bit r, input bit g0, input bit g1,
                      input bit [7:0] d0, input bit [7:0] d1);
    reset  = r;
    gnt_0  = g0;
    gnt_1  = g1;
    data_0 = d0;
    data_1 = d1;
    @(posedge clock);
    cyc++;
    model_edge(r, g0, g1, d0, d1);
    #1;
    chk("txd",    32'(txd),    32'(m_act ? frame_level(m_t, m_byte) : 1'b1));
    chk("busy",   32'(busy),   32'(m_act));
    chk("done_0", 32'(done_0), 32'(m_pulse && !m_psrc));
    chk("done_1", 32'(done_1), 32'(m_pulse &&  m_psrc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  int       d0_count;
  bit       rg0, rg1, rrst;
  bit [7:0] rd0, rd1;

  initial begin
    // reset with a grant present: must be ignored
    step(1'b1, 1'b1, 1'b0, 8'h55, 8'h00);
    step(1'b1, 1'b1, 1'b1, 8'h55, 8'h66);
    idle(3);

    // single source-0 frame of A5
    step(1'b0, 1'b1, 1'b0, 8'hA5, 8'h00);
    idle(FRAME + 4);

    // collision: source 0 wins
    step(1'b0, 1'b1, 1'b1, 8'h0F, 8'hF0);
    idle(FRAME + 4);

    // gnt_1 held across two frames: 2-cycle gap then second frame
    for (int i = 0; i < 2 * FRAME + 6; i++) step(1'b0, 1'b0, 1'b1, 8'h00, 8'hC3);
    idle(FRAME + 4);

    // reset at cycle 15 of a frame, then a fresh full frame
    step(1'b0, 1'b1, 1'b0, 8'h96, 8'h00);
    idle(14);
    step(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    idle(3);
    step(1'b0, 1'b1, 1'b0, 8'h3A, 8'h00);
    idle(FRAME + 4);

    // data_1 changes mid-frame; latched 3C must be sent
    step(1'b0, 1'b0, 1'b1, 8'h00, 8'h3C);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'h3C);
    for (int i = 0; i < FRAME; i++) step(1'b0, 1'b0, 1'b0, 8'h00, 8'hFF);

    // gnt_0 pulsed while busy: ignored, exactly one done_0
    d0_count = 0;
    step(1'b0, 1'b1, 1'b0, 8'h81, 8'h00);
    for (int i = 0; i < FRAME + 6; i++) begin
      step(1'b0, (i == 10 || i == 25), 1'b0, 8'h7E, 8'h00);
      if (done_0) d0_count++;
    end
    chk("done_0_count", 32'(d0_count), 32'd1);

    // randomized traffic with held grants, data churn and rare resets
    rg0 = 0; rg1 = 0; rd0 = 0; rd1 = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0)  rg0 = 1'($urandom);
      if ($urandom_range(0, 7) == 0)  rg1 = 1'($urandom);
      if ($urandom_range(0, 3) == 0)  rd0 = 8'($urandom);
      if ($urandom_range(0, 3) == 0)  rd1 = 8'($urandom);
      rrst = ($urandom_range(0, 399) == 0);
      step(rrst, rg0, rg1, rd0, rd1);
    end
    idle(FRAME + 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
